fan_tach_meter: RTL and testbench

Measures fan speed from the open-collector tachometer line and delivers it as an ADC-style sample to the fan control loop. It sits directly upstream of the fan controller. It synchronises and deglitches the tach input, counts falling edges over a fixed gate window, and presents the saturated count on `ADC_value_o` with a one-cycle `dataValid_STRB_o`. Those two outputs connect straight to the controller's `ADC_value_i` and `dataVaild_STRB_i`.

---
 rtl/fan_ctrl_pkg.sv | 26 ++
 rtl/tach_debounce.sv | 62 ++++++
 rtl/fan_tach_meter.sv | 193 +++++++++++++++++++
 tb/tb_fan_tach_meter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared constants for the fan control path: default ADC width, tach idle
// level and the counter-width helpers used to size the tach meter counters.
package fan_ctrl_pkg;

    localparam int ADC_BITWIDTH_DEF  = 32'sd8;
    localparam int GATE_TICKS_DEF    = 32'sd100000;
    localparam int DEBOUNCE_LEN_DEF  = 32'sd4;
    localparam int STALL_WINDOWS_DEF = 32'sd3;

    // Open-collector tach line idles high; pulses pull it low.
    localparam logic TACH_IDLE = 1'b1;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        if (max_val < 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(max_val + 32'sd1);
        end
    endfunction

    localparam int GATE_CNT_W_DEF  = cnt_width(GATE_TICKS_DEF - 32'sd1);
    localparam int RUN_CNT_W_DEF   = cnt_width(DEBOUNCE_LEN_DEF);
    localparam int STALL_CNT_W_DEF = cnt_width(STALL_WINDOWS_DEF);

endpackage

// File: rtl/tach_debounce.sv
// Tach level filter: the accepted level only follows the synchronised input
// after DEBOUNCE_LEN consecutive enabled samples of the opposite level.
// fall_o flags the enabled cycle in which the accepted level goes 1 -> 0, so
// the meter can count the edge on the same clock edge the level updates.
module tach_debounce
    import fan_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LEN = DEBOUNCE_LEN_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk_en_i,
    input  logic sample_i,
    output logic fall_o
);

    localparam int               RUN_W    = cnt_width(DEBOUNCE_LEN);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_LEN - 32'sd1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(32'd1);
    localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};

    logic [RUN_W-1:0] run_r;
    logic             tach_f_r;
    logic             accept_s;
    logic             fall_s;

    // This enabled sample completes a full run of the opposite level.
    always_comb begin
        accept_s = 1'b0;
        fall_s   = 1'b0;
        if (clk_en_i && (sample_i != tach_f_r) && (run_r == RUN_LAST)) begin
            accept_s = 1'b1;
            fall_s   = tach_f_r;
        end else begin
            accept_s = 1'b0;
            fall_s   = 1'b0;
        end
    end

    assign fall_o = fall_s;

    // Run counter and accepted level; a matching sample restarts the run.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_r    <= RUN_ZERO;
            tach_f_r <= TACH_IDLE;
        end else if (clk_en_i) begin
            if (sample_i == tach_f_r) begin
                run_r <= RUN_ZERO;
            end else if (accept_s) begin
                run_r    <= RUN_ZERO;
                tach_f_r <= sample_i;
            end else begin
                run_r <= run_r + RUN_ONE;
            end
        end else begin
            run_r    <= run_r;
            tach_f_r <= tach_f_r;
        end
    end

endmodule

// File: rtl/fan_tach_meter.sv
// Fan tachometer meter: synchronises the tach line, optionally deglitches it,
// counts falling edges over a fixed window of clk_en_i ticks and publishes the
// saturated count as an ADC-style sample with a one-cycle strobe.
// Build option: define FANTACH_DEBOUNCE_EN to insert the tach_debounce filter;
// without it the synchroniser output is used directly.
module fan_tach_meter
    import fan_ctrl_pkg::*;
#(
    parameter int ADC_BITWIDTH  = ADC_BITWIDTH_DEF,
    parameter int GATE_TICKS    = GATE_TICKS_DEF,
    parameter int DEBOUNCE_LEN  = DEBOUNCE_LEN_DEF,
    parameter int STALL_WINDOWS = STALL_WINDOWS_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clk_en_i,
    input  logic                    tach_i,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic                    dataValid_STRB_o,
    output logic                    overflow_o,
    output logic                    stall_o
);

    localparam int PCNT_W  = ADC_BITWIDTH + 32'sd1;
    localparam int GATE_W  = cnt_width(GATE_TICKS - 32'sd1);
    localparam int STALL_W = cnt_width(STALL_WINDOWS);

    localparam logic [PCNT_W-1:0]       PCNT_ZERO   = {PCNT_W{1'b0}};
    localparam logic [PCNT_W-1:0]       PCNT_ONE    = PCNT_W'(32'd1);
    localparam logic [PCNT_W-1:0]       PCNT_MAX    = {PCNT_W{1'b1}};
    localparam logic [PCNT_W-1:0]       ADC_MAX_EXT = {1'b0, {ADC_BITWIDTH{1'b1}}};
    localparam logic [ADC_BITWIDTH-1:0] ADC_MAX     = {ADC_BITWIDTH{1'b1}};
    localparam logic [ADC_BITWIDTH-1:0] ADC_ZERO    = {ADC_BITWIDTH{1'b0}};
    localparam logic [GATE_W-1:0]       GATE_ZERO   = {GATE_W{1'b0}};
    localparam logic [GATE_W-1:0]       GATE_ONE    = GATE_W'(32'd1);
    localparam logic [GATE_W-1:0]       GATE_LAST   = GATE_W'(GATE_TICKS - 32'sd1);
    localparam logic [STALL_W-1:0]      STALL_ZERO  = {STALL_W{1'b0}};
    localparam logic [STALL_W-1:0]      STALL_ONE   = STALL_W'(32'd1);
    localparam logic [STALL_W-1:0]      STALL_FULL  = STALL_W'(STALL_WINDOWS);

    // Parameter ranges the counters are sized for.
    if ((GATE_TICKS < 32'sd2) || (DEBOUNCE_LEN < 32'sd1) || (STALL_WINDOWS < 32'sd1)) begin : g_bad_cfg
        $error("fan_tach_meter: GATE_TICKS>=2, DEBOUNCE_LEN>=1, STALL_WINDOWS>=1 required");
    end

    logic [1:0]          sync_r;
    logic                tach_sync_s;
    logic                fall_s;
    logic                count_en_s;
    logic                term_s;
    logic [GATE_W-1:0]   gate_r;
    logic [PCNT_W-1:0]   pcnt_r;
    logic [STALL_W-1:0]  stall_cnt_r;
    logic [STALL_W-1:0]  stall_next_s;
    logic [ADC_BITWIDTH-1:0] adc_next_s;
    logic                ovf_next_s;
    logic [ADC_BITWIDTH-1:0] adc_value_r;
    logic                strobe_r;
    logic                overflow_r;
    logic                stall_r;

    // Two-flop synchroniser on the asynchronous tach line, runs every clk_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_r <= {2{TACH_IDLE}};
        end else begin
            sync_r <= {sync_r[0], tach_i};
        end
    end

    assign tach_sync_s = sync_r[1];

`ifdef FANTACH_DEBOUNCE_EN
    tach_debounce #(
        .DEBOUNCE_LEN (DEBOUNCE_LEN)
    ) u_tach_debounce (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clk_en_i (clk_en_i),
        .sample_i (tach_sync_s),
        .fall_o   (fall_s)
    );
`else
    logic tach_f_s;
    logic tach_prev_r;

    assign tach_f_s = tach_sync_s;

    // Previous accepted level, tracked every clk_i for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tach_prev_r <= TACH_IDLE;
        end else begin
            tach_prev_r <= tach_f_s;
        end
    end

    // A 1 -> 0 transition of the accepted level is one tach pulse.
    always_comb begin
        fall_s = 1'b0;
        if (tach_prev_r && !tach_f_s) begin
            fall_s = 1'b1;
        end else begin
            fall_s = 1'b0;
        end
    end
`endif

    // Edges count only on enabled ticks; the terminal tick closes the window.
    always_comb begin
        count_en_s = 1'b0;
        term_s     = 1'b0;
        if (clk_en_i) begin
            count_en_s = fall_s;
            term_s     = (gate_r == GATE_LAST);
        end else begin
            count_en_s = 1'b0;
            term_s     = 1'b0;
        end
    end

    // Gate counter: 0 .. GATE_TICKS-1 then wrap, no dead time between windows.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gate_r <= GATE_ZERO;
        end else if (term_s) begin
            gate_r <= GATE_ZERO;
        end else if (clk_en_i) begin
            gate_r <= gate_r + GATE_ONE;
        end else begin
            gate_r <= gate_r;
        end
    end

    // Saturating pulse counter; an edge on the terminal tick opens the next window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_r <= PCNT_ZERO;
        end else if (term_s) begin
            pcnt_r <= count_en_s ? PCNT_ONE : PCNT_ZERO;
        end else if (count_en_s && (pcnt_r != PCNT_MAX)) begin
            pcnt_r <= pcnt_r + PCNT_ONE;
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

    // Window result: clamped value, overflow flag and next stall count.
    always_comb begin
        adc_next_s   = ADC_ZERO;
        ovf_next_s   = 1'b0;
        stall_next_s = STALL_ZERO;
        if (pcnt_r > ADC_MAX_EXT) begin
            adc_next_s = ADC_MAX;
            ovf_next_s = 1'b1;
        end else begin
            adc_next_s = pcnt_r[ADC_BITWIDTH-1:0];
            ovf_next_s = 1'b0;
        end
        if (pcnt_r != PCNT_ZERO) begin
            stall_next_s = STALL_ZERO;
        end else if (stall_cnt_r != STALL_FULL) begin
            stall_next_s = stall_cnt_r + STALL_ONE;
        end else begin
            stall_next_s = stall_cnt_r;
        end
    end

    // Registered outputs, updated together on the terminal tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adc_value_r <= ADC_ZERO;
            strobe_r    <= 1'b0;
            overflow_r  <= 1'b0;
            stall_r     <= 1'b0;
            stall_cnt_r <= STALL_ZERO;
        end else if (term_s) begin
            adc_value_r <= adc_next_s;
            strobe_r    <= 1'b1;
            overflow_r  <= ovf_next_s;
            stall_r     <= (stall_next_s == STALL_FULL);
            stall_cnt_r <= stall_next_s;
        end else begin
            strobe_r    <= 1'b0;
        end
    end

    assign ADC_value_o      = adc_value_r;
    assign dataValid_STRB_o = strobe_r;
    assign overflow_o       = overflow_r;
    assign stall_o          = stall_r;

endmodule

// File: tb/tb_fan_tach_meter.sv
// Directed bench for fan_tach_meter: two instances (8-bit and 4-bit ADC width)
// share one tach stimulus; expected values are hand-computed per window.
`timescale 1ns/1ps
module tb_fan_tach_meter;

    localparam int GATE  = 100;
    localparam int DEB   = 3;
    localparam int STALL = 2;

`ifdef FANTACH_DEBOUNCE_EN
    // tach_i low driven after posedge P(n) is counted at posedge P(n+5)
    localparam int LAT    = 5;
    localparam int GL_EXP = 3;
    localparam int OV_N   = 16;
    localparam int OV_LO  = 3;
    localparam int OV_HI  = 3;
`else
    localparam int LAT    = 3;
    localparam int GL_EXP = 13;
    localparam int OV_N   = 20;
    localparam int OV_LO  = 2;
    localparam int OV_HI  = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       tach;
    logic [7:0] val8;
    logic       stb8, ovf8, stl8;
    logic [3:0] val4;
    logic       stb4, ovf4, stl4;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;
    int rel_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fan_tach_meter #(
        .ADC_BITWIDTH (8), .GATE_TICKS (GATE), .DEBOUNCE_LEN (DEB), .STALL_WINDOWS (STALL)
    ) u_dut8 (
        .clk_i (clk), .rst_i (rst), .clk_en_i (clk_en), .tach_i (tach),
        .ADC_value_o (val8), .dataValid_STRB_o (stb8), .overflow_o (ovf8), .stall_o (stl8)
    );

    fan_tach_meter #(
        .ADC_BITWIDTH (4), .GATE_TICKS (GATE), .DEBOUNCE_LEN (DEB), .STALL_WINDOWS (STALL)
    ) u_dut4 (
        .clk_i (clk), .rst_i (rst), .clk_en_i (clk_en), .tach_i (tach),
        .ADC_value_o (val4), .dataValid_STRB_o (stb4), .overflow_o (ovf4), .stall_o (stl4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One low pulse: low for lo cycles, then high for hi cycles.
    task automatic pulse(input int lo, input int hi);
        @(posedge clk);
        #1 tach = 1'b0;
        repeat (lo) @(posedge clk);
        #1 tach = 1'b1;
        repeat (hi - 1) @(posedge clk);
    endtask

    // Wait (bounded) for the strobe; returns on the negedge where it is seen.
    task automatic wait_strobe(input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (stb8 === 1'b1) seen = 1'b1;
        end
        check_eq({tag, "_strobe_seen"}, {31'd0, seen}, 32'd1);
        check_eq({tag, "_strobe4"}, {31'd0, stb4}, 32'd1);
    endtask

    task automatic check_win(input string tag, input int v8, input int o8,
                             input int v4, input int o4, input int st);
        check_eq({tag, "_val8"}, {24'd0, val8}, v8);
        check_eq({tag, "_ovf8"}, {31'd0, ovf8}, o8);
        check_eq({tag, "_val4"}, {28'd0, val4}, v4);
        check_eq({tag, "_ovf4"}, {31'd0, ovf4}, o4);
        check_eq({tag, "_stall"}, {31'd0, stl8}, st);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_val8"}, {24'd0, val8}, 32'd0);
        check_eq({tag, "_stb8"}, {31'd0, stb8}, 32'd0);
        check_eq({tag, "_ovf8"}, {31'd0, ovf8}, 32'd0);
        check_eq({tag, "_stall8"}, {31'd0, stl8}, 32'd0);
        check_eq({tag, "_val4"}, {28'd0, val4}, 32'd0);
        check_eq({tag, "_stb4"}, {31'd0, stb4}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        clk_en = 1'b1;
        tach   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        rel_cyc = cyc;

        // Window 1: 7 clean pulses
        for (int i = 0; i < 7; i++) pulse(5, 5);
        wait_strobe("w1");
        check_eq("w1_period", cyc - rel_cyc, 32'd100);
        check_win("w1", 7, 0, 7, 0, 0);
        @(negedge clk);
        check_eq("w1_strobe_one_cycle", {31'd0, stb8}, 32'd0);
        check_eq("w1_hold_val", {24'd0, val8}, 32'd7);

        // Window 2: 10 two-cycle glitches plus 3 clean pulses
        for (int i = 0; i < 10; i++) pulse(2, 3);
        for (int i = 0; i < 3; i++) pulse(5, 5);
        wait_strobe("w2");
        check_win("w2", GL_EXP, 0, GL_EXP, 0, 0);

        // Window 3: overflow on the 4-bit instance
        for (int i = 0; i < OV_N; i++) pulse(OV_LO, OV_HI);
        wait_strobe("w3");
        check_win("w3", OV_N, 0, 15, 1, 0);

        // Window 4: 2 pulses clears overflow
        for (int i = 0; i < 2; i++) pulse(5, 5);
        wait_strobe("w4");
        check_win("w4", 2, 0, 2, 0, 0);

        // Windows 5-7: stall after two empty windows, cleared by one pulse
        wait_strobe("w5");
        check_win("w5", 0, 0, 0, 0, 0);
        wait_strobe("w6");
        check_win("w6", 0, 0, 0, 0, 1);
        pulse(5, 5);
        wait_strobe("w7");
        check_win("w7", 1, 0, 1, 0, 0);

        // Window 8/9: edge accepted exactly on terminal tick 99
        repeat (GATE - LAT) @(posedge clk);
        #1 tach = 1'b0;
        wait_strobe("w8");
        check_win("w8", 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1 tach = 1'b1;
        wait_strobe("w9");
        check_win("w9", 1, 0, 1, 0, 0);

        // Reset at tick 50 after 4 counted pulses
        for (int i = 0; i < 4; i++) pulse(5, 5);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        rel_cyc = cyc;
        wait_strobe("w10");
        check_eq("w10_period", cyc - rel_cyc, 32'd100);
        check_win("w10", 0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("w10_strobe_one_cycle", {31'd0, stb8}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
